uart_rx_core: RTL and testbench

Parametrised, oversampling UART receiver that succeeds the fixed 8-bit receiver in the serial subsystem. Converts the asynchronous `rx` line into DATA_BITS-wide words using the `rx_clk_en` oversample tick from the shared baud generator. Adds false-start rejection, optional parity, 1 or 2 stop bits, framing/overrun detection and a valid/ready output handshake. Sits between the baud generator and the downstream consumer (register file or FIFO).

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync2.sv | 34 +++
 rtl/uart_rx_core.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and the future
// transmitter.
//   uart_state_e : receiver FSM state encoding
//   PAR_*        : parity_mode encodings (2'b11 is treated as none)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for the asynchronous serial line.
// Both flops reset to 1 so an idle line never looks like a start bit.
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   d     in  asynchronous input
//   q     out synchronised output (2-cycle latency)
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with false-start rejection,
// optional parity, 1/2 stop bits, framing/overrun detection and a
// valid/ready output handshake.
// Build option: define UART_RX_PARITY_EN to include the PARITY state and
// parity check; otherwise parity_mode is ignored and parity_err is 0.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   rx_clk_en         oversample tick (OVERSAMPLE per bit)
//   rx                serial line, idle high, LSB first
//   rx_en             receiver enable (low aborts frame, forces IDLE)
//   parity_mode       00 none, 01 even, 10 odd, 11 none
//   data_out          received word, held while data_valid
//   data_valid/ready  output handshake
//   parity_err        parity mismatch for held word
//   frame_err         low stop bit for held word
//   overrun_err       one-cycle pulse when a word is dropped
//   busy              FSM not in IDLE
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_clk_en,
  input  logic                 rx,
  input  logic                 rx_en,
  input  logic [1:0]           parity_mode,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  logic rx_s;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bitpos_q, bitpos_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 deliver;
  logic                 accept;
`ifdef UART_RX_PARITY_EN
  logic                 perr_acc_q, perr_acc_d;
  logic                 parity_err_q, parity_err_d;
  logic                 par_on;

  assign par_on = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
`else
  logic                 unused_parity_mode;

  assign unused_parity_mode = ^parity_mode;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitpos_d   = bitpos_q;
    shreg_d    = shreg_q;
    ferr_acc_d = ferr_acc_q;
    deliver    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_acc_d = perr_acc_q;
`endif

    if (!rx_en) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      bitpos_d = '0;
    end else if (rx_clk_en) begin
      case (state_q)
        ST_IDLE: begin
          // The first low sample already counts as tick 0 of the start bit.
          if (!rx_s) begin
            state_d    = ST_START;
            cnt_d      = CW'(1);
            ferr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_acc_d = 1'b0;
`endif
          end
        end
        ST_START: begin
          if (rx_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == HALF_M1) begin
            state_d  = ST_DATA;
            cnt_d    = '0;
            bitpos_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_d            = '0;
            shreg_d[bitpos_q] = rx_s;
            if (bitpos_q == LAST_BIT) begin
              bitpos_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d  = par_on ? ST_PARITY : ST_STOP;
`else
              state_d  = ST_STOP;
`endif
            end else begin
              bitpos_d = bitpos_q + BW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q == FULL_M1) begin
            cnt_d      = '0;
            perr_acc_d = ((^shreg_q) ^ rx_s) != (parity_mode == PAR_ODD);
            state_d    = ST_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_d = '0;
            if (!rx_s) ferr_acc_d = 1'b1;
            if (bitpos_q == LAST_STOP) begin
              bitpos_d = '0;
              deliver  = 1'b1;
              state_d  = rx_s ? ST_IDLE : ST_WAIT_HIGH;
            end else begin
              bitpos_d = bitpos_q + BW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_s) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Delivery sees this cycle's acceptance, so a word arriving in the same
  // cycle the previous one is taken is loaded rather than dropped.
  always_comb begin
    accept        = data_valid_q && data_ready;
    data_out_d    = data_out_q;
    data_valid_d  = data_valid_q;
    frame_err_d   = frame_err_q;
    overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d  = parity_err_q;
`endif

    if (accept) begin
      data_valid_d = 1'b0;
      frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end

    if (deliver) begin
      if (!data_valid_q || accept) begin
        data_out_d   = shreg_q;
        data_valid_d = 1'b1;
        frame_err_d  = ferr_acc_d;
`ifdef UART_RX_PARITY_EN
        parity_err_d = perr_acc_q;
`endif
      end else begin
        overrun_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bitpos_q      <= '0;
      shreg_q       <= '0;
      ferr_acc_q    <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_acc_q    <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bitpos_q      <= bitpos_d;
      shreg_q       <= shreg_d;
      ferr_acc_q    <= ferr_acc_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      perr_acc_q    <= perr_acc_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: table-driven frames plus hand-written corner sequences
// for uart_rx_core (DATA_BITS=8, OVERSAMPLE=16, STOP_BITS=1, tick every
// cycle). Expected words go into a queue when a frame is sent and are
// compared when the receiver presents a new word.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_clk_en;
  logic       rx;
  logic       rx_en;
  logic [1:0] parity_mode;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  uart_rx_core #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .STOP_BITS  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_clk_en   (rx_clk_en),
    .rx          (rx),
    .rx_en       (rx_en),
    .parity_mode (parity_mode),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] pmode;
    bit         send_par;
    logic       pbit;
    logic       exp_perr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_overrun = 0;
  int   cyc = 0;
  int   frame_start_cyc = 0;
  int   last_valid_cyc = 0;
  bit   prev_valid = 1'b0;
  bit   prev_accept = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a new word is a valid cycle not continuing an unaccepted one.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (overrun_err) n_overrun++;
      if (data_valid && (!prev_valid || prev_accept)) begin
        last_valid_cyc = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_word got data=%h perr=%b ferr=%b", data_out, parity_err, frame_err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({data_out, parity_err, frame_err} !== {e.data, e.perr, e.ferr}) begin
            n_bad++;
            $display("FAIL word got data=%h perr=%b ferr=%b expected data=%h perr=%b ferr=%b",
                     data_out, parity_err, frame_err, e.data, e.perr, e.ferr);
          end
        end
      end
      prev_valid  = data_valid;
      prev_accept = data_valid && data_ready;
    end else begin
      prev_valid  = 1'b0;
      prev_accept = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Leaves rx at the stop value so callers can stretch a low stop bit.
  task automatic send_frame(input logic [7:0] d, input bit with_par, input logic pbit,
                            input logic stop_val);
    rx = 1'b0;
    frame_start_cyc = cyc;
    step(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(16);
    end
    if (with_par) begin
      rx = pbit;
      step(16);
    end
    rx = stop_val;
    step(16);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic perr, input logic ferr);
    exp_t e;
    e.data = d;
    e.perr = perr;
    e.ferr = ferr;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int w = 0; w < 60 && exp_q.size() != 0; w++) step(1);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout got pending=%0d expected pending=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    rx          = 1'b1;
    rx_en       = 1'b1;
    rx_clk_en   = 1'b1;
    data_ready  = 1'b1;
    parity_mode = 2'b00;

    vecs.push_back('{8'hA5, 2'b00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 2'b00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 2'b00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 2'b00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h01, 2'b11, 1'b0, 1'b0, 1'b0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 2'b01, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{8'h07, 2'b10, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h03, 2'b01, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h03, 2'b10, 1'b1, 1'b0, 1'b1});
`else
    vecs.push_back('{8'h07, 2'b01, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h07, 2'b10, 1'b0, 1'b0, 1'b0});
`endif

    step(3);
    rst_n = 1'b1;
    step(1);
    check("reset_data_out", {24'h0, data_out}, 32'h0);
    check("reset_data_valid", {31'h0, data_valid}, 32'h0);
    check("reset_parity_err", {31'h0, parity_err}, 32'h0);
    check("reset_frame_err", {31'h0, frame_err}, 32'h0);
    check("reset_overrun_err", {31'h0, overrun_err}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);

    // Latency: 2 synchroniser cycles + 8 start ticks + 16 per bit after it.
    foreach (vecs[i]) begin
      int lat;
      parity_mode = vecs[i].pmode;
      push_exp(vecs[i].data, vecs[i].exp_perr, 1'b0);
      send_frame(vecs[i].data, vecs[i].send_par, vecs[i].pbit, 1'b1);
      step(4);
      drain("table_frame");
      lat = 2 + 8 + 16 * (8 + (vecs[i].send_par ? 1 : 0) + 1);
      check("table_latency", last_valid_cyc - frame_start_cyc, lat);
    end
    parity_mode = 2'b00;

    // Start glitch of 4 ticks is rejected.
    begin
      int words_before;
      words_before = n_cmp;
      rx = 1'b0;
      step(4);
      rx = 1'b1;
      check("glitch_busy_high", {31'h0, busy}, 32'h1);
      step(12);
      check("glitch_busy_low", {31'h0, busy}, 32'h0);
      check("glitch_no_valid", {31'h0, data_valid}, 32'h0);
    end

    // Low stop bit, line held low: WAIT_HIGH keeps busy until the line rises.
    push_exp(8'h96, 1'b0, 1'b1);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0);
    step(10);
    check("wait_high_busy", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    step(6);
    check("wait_high_exit", {31'h0, busy}, 32'h0);
    drain("frame_err");
    push_exp(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    step(4);
    drain("after_frame_err");

    // Overrun: second word dropped while the first is unaccepted.
    data_ready = 1'b0;
    n_overrun  = 0;
    push_exp(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    step(4);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    step(4);
    drain("overrun_first");
    check("overrun_data_held", {24'h0, data_out}, 32'h11);
    check("overrun_valid_held", {31'h0, data_valid}, 32'h1);
    check("overrun_pulses", n_overrun, 1);
    data_ready = 1'b1;
    step(1);
    check("accept_valid_low", {31'h0, data_valid}, 32'h0);
    step(2);

    // Reset mid-DATA discards the partial frame.
    rx = 1'b0;
    step(16);
    rx = 1'b1;
    step(16);
    rx = 1'b0;
    step(20);
    rst_n = 1'b0;
    rx    = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(4);
    check("midreset_valid", {31'h0, data_valid}, 32'h0);
    check("midreset_busy", {31'h0, busy}, 32'h0);
    push_exp(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    step(4);
    drain("after_reset");
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
